// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO between uart_rx and the
// ALU interface. Pushes come from one-cycle rx_done strobes; the consumer pops
// with i_rd while o_valid is high. A push into a full FIFO is dropped and
// raises the sticky o_overflow flag. Push and pop in the same cycle at full
// both take place, so no byte is lost in that case.
//
// Optional feature: define UART_FIFO_DROP_CNT_EN to add o_drop_cnt, a
// saturating 8-bit count of dropped pushes. i_clr_ovf clears this count
// together with o_overflow.
module uart_rx_fifo #(
    parameter int N_DATA     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_DATA-1:0]     i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_rd,
    input  logic                  i_clr_ovf,
    output logic [N_DATA-1:0]     o_data,
    output logic                  o_valid,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_count,
`ifdef UART_FIFO_DROP_CNT_EN
    output logic [7:0]            o_drop_cnt,
`endif
    output logic                  o_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Occupancy value that means "every entry holds a byte"
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [N_DATA-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_q, wp_d;
    logic [DEPTH_LOG2-1:0] rp_q, rp_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;

    logic valid_s;
    logic full_s;
    logic pop_s;
    logic wr_en_s;
    logic drop_s;

    // Status decoded from the occupancy register only
    always_comb begin
        valid_s = (cnt_q != {(DEPTH_LOG2+1){1'b0}});
        full_s  = (cnt_q == FULL_CNT);
    end

    // Push/pop qualification and next-state for pointers, count and flag
    always_comb begin
        pop_s   = i_rd & valid_s;
        // A push is stored unless the FIFO is full and nothing leaves this cycle
        wr_en_s = i_rx_done & (~full_s | pop_s);
        drop_s  = i_rx_done & full_s & ~pop_s;

        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;

        if (wr_en_s) begin
            wp_d = wp_q + DEPTH_LOG2'(1);
        end else begin
            wp_d = wp_q;
        end

        if (pop_s) begin
            rp_d = rp_q + DEPTH_LOG2'(1);
        end else begin
            rp_d = rp_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   cnt_d = cnt_q + (DEPTH_LOG2+1)'(1);
            2'b01:   cnt_d = cnt_q - (DEPTH_LOG2+1)'(1);
            default: cnt_d = cnt_q;
        endcase

        // A drop in the same cycle as a clear keeps the flag set
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Pointer, occupancy and overflow registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wp_q  <= {DEPTH_LOG2{1'b0}};
            rp_q  <= {DEPTH_LOG2{1'b0}};
            cnt_q <= {(DEPTH_LOG2+1){1'b0}};
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage array; contents are never read while empty, so it has no reset
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem_q[wp_q] <= i_rx_data;
        end
    end

`ifdef UART_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop counter; a drop coinciding with a clear leaves it at 1
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (i_clr_ovf && drop_s) begin
            drop_cnt_d = 8'd1;
        end else if (i_clr_ovf) begin
            drop_cnt_d = 8'd0;
        end else if (drop_s && (drop_cnt_q != 8'd255)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Drop count output straight from its register
    always_comb begin
        o_drop_cnt = drop_cnt_q;
    end
`endif

    // Outputs depend on registers only; the head reads as zero when empty
    always_comb begin
        o_valid    = valid_s;
        o_full     = full_s;
        o_count    = cnt_q;
        o_overflow = ovf_q;
        if (valid_s) begin
            o_data = mem_q[rp_q];
        end else begin
            o_data = {N_DATA{1'b0}};
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte FIFO between `uart_rx` and `uart_alu_interface` in the UART–ALU datapath. It absorbs bytes arriving as `rx_done` pulses and presents them first-word-fall-through with a valid/pop handshake. The interface can then be busy, for example waiting on `uart_tx`, without losing operand or opcode bytes. Overflow is flagged sticky, and the dropped byte is discarded.

## Interface
Parameters:
- `N_DATA`, 8, byte width.
- `DEPTH_LOG2`, 4, log2 of the entry count (DEPTH = 16).

Ports:
- `i_clk`  in  1  system clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, asynchronous and active-low.
- `i_rx_data`  in  N_DATA  byte from `uart_rx`; sampled only when `i_rx_done`=1.
- `i_rx_done`  in  1  one-cycle push strobe from `uart_rx`.
- `i_rd`  in  1  pop request from the consumer.
- `i_clr_ovf`  in  1  clears `o_overflow`.
- `o_data`  out  N_DATA  head entry; 0 when empty.
- `o_valid`  out  1  FIFO non-empty; `o_data` is meaningful.
- `o_full`  out  1  count == DEPTH.
- `o_count`  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- `o_overflow`  out  1  sticky: a push was dropped.

## Operation
Storage and pointers:
- Storage is DEPTH x N_DATA registers, with write pointer `wp`, read pointer `rp` and occupancy `cnt`.
- `wp` and `rp` are DEPTH_LOG2 bits wide and wrap modulo DEPTH with no special handling.

Push and pop qualification:
- push = `i_rx_done`.
- pop = `i_rd` & `o_valid`. A pop while empty is ignored and has no side effects.

Per-cycle cases:
- Push only, not full: write `mem[wp]`, `wp`+1, `cnt`+1.
- Push only, full: byte dropped; `wp`, `cnt` and memory unchanged; `o_overflow` set to 1.
- Pop only: `rp`+1, `cnt`−1.
- Push and pop, non-empty (including full): both performed; `cnt` unchanged; no overflow.
- Push and pop, empty: the pop is ignored and the push is performed; `cnt` goes to 1.

Outputs and flags:
- `o_valid` = (`cnt` != 0), `o_full` = (`cnt` == DEPTH), `o_count` = `cnt`, all driven from registers.
- `o_data` = `mem[rp]` when `o_valid`=1, else 0.
- `o_overflow` is cleared by `i_clr_ovf`. If a dropping push coincides with `i_clr_ovf`, set wins and `o_overflow` stays 1.

Reset:
- Applies asynchronously on `i_rst`=0 and releases synchronously to `i_clk` (no mid-cycle effects after deassertion).
- Values during reset: `wp`=`rp`=0, `cnt`=0, `o_overflow`=0, so `o_valid`=0, `o_full`=0, `o_count`=0 and `o_data`=0.
- Memory contents are not reset and are unobservable while empty.
- Reset during any activity discards all stored bytes immediately.

## Timing
- Push-to-valid latency is 1 cycle: after the edge that samples `i_rx_done`=1 into an empty FIFO, `o_valid`=1 and `o_data` equals that byte.
- Pop: the consumer samples `o_data` while `o_valid`=1 and asserts `i_rd` that cycle. The next head appears after that edge.
- Back-to-back pops at one per cycle are supported until empty.
- No combinational path from `i_rx_done` or `i_rx_data` to any output.
- `o_data`, `o_valid`, `o_full` and `o_count` are combinational from registers only; `i_rd` has no combinational path to outputs.
- `i_rx_done` is at most one pulse per UART frame. The FIFO must nonetheless accept a push on every cycle.

## Configuration
`UART_FIFO_DROP_CNT_EN`:
- Defined: adds output `o_drop_cnt` [7:0], incremented on every dropped push and saturating at 255.
  - It is cleared to 0 by `i_clr_ovf` and reset to 0.
  - If a drop coincides with `i_clr_ovf`, the result is 1.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold `i_rst`=0 mid-stream with 5 bytes stored → `o_count`=0, `o_valid`=0, `o_data`=0 asynchronously. After release, push 0xA5 → next cycle `o_valid`=1, `o_data`=0xA5.
- Ordering and wrap: push 0x00..0x0F (16 bytes) → `o_full`=1, `o_count`=16. Pop 8, push 0x10..0x17, then pop all → output sequence 0x00..0x17 in order, `o_valid`=0 at the end.
- Overflow: fill with 16 bytes, push 0xEE → `o_overflow`=1, `o_count`=16, and 0xEE is never popped. Assert `i_clr_ovf` → `o_overflow`=0; with the macro, `o_drop_cnt` goes 1→0.
- Simultaneous at full: full, push 0x55 and pop in the same cycle → `o_count` stays 16, no overflow, 0x55 emerges last.
- Simultaneous at empty: empty, push 0x3C and assert `i_rd` → `o_count`=1, `o_data`=0x3C. A pop while empty alone leaves `o_count`=0.
- Drop saturation (macro defined): 300 pushes into a full FIFO → `o_drop_cnt`=255. A drop with `i_clr_ovf`=1 → `o_drop_cnt`=1, `o_overflow`=1.
